// File: rtl/genius_sequence_player.sv
// Genius colour sequence player: stores the colour sequence and replays it as frame-timed
// codeColor highlights. Define GENIUS_SEQ_SPEEDUP_EN to shorten the lit time of later steps.
module genius_sequence_player #(
    parameter int unsigned DEPTH_LOG2    = 5,
    parameter int unsigned ON_FRAMES     = 30,
    parameter int unsigned OFF_FRAMES    = 15,
    parameter int unsigned MIN_ON_FRAMES = 6
) (
    input  logic                  iVGA_CLK,
    input  logic                  iRST_n,
    input  logic                  iVS,
    input  logic                  iWr,
    input  logic [DEPTH_LOG2-1:0] iWrAddr,
    input  logic [1:0]            iWrColor,
    input  logic [DEPTH_LOG2:0]   iSeqLen,
    input  logic                  iStart,
    input  logic                  iAbort,
    output logic [3:0]            oCodeColor,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [DEPTH_LOG2-1:0] oStep
);

    typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

    localparam int unsigned         Depth      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] MaxLen     = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [8:0]          OnFrames9  = 9'(ON_FRAMES);
    localparam logic [8:0]          MinOn9     = 9'(MIN_ON_FRAMES);
    localparam logic [7:0]          OnFrames8  = 8'(ON_FRAMES);
    localparam logic [7:0]          OffFrames8 = 8'(OFF_FRAMES);
`ifdef GENIUS_SEQ_SPEEDUP_EN
    localparam bit SpeedupEn = 1'b1;
`else
    localparam bit SpeedupEn = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [1:0]            ram_q [Depth];
    logic                  vs_q, tick;
    logic [DEPTH_LOG2-1:0] step_q, step_d;
    logic [7:0]            fcnt_q, fcnt_d, fcnt_inc, on_time;
    logic [DEPTH_LOG2:0]   len_q, len_d, len_clamped;
    logic [3:0]            code_q, code_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [8:0]            two_k, on_diff, on_speed;
    logic                  last_step;

    // Falling edge of vertical sync marks one whole frame.
    assign tick = vs_q & ~iVS;

    // Sequence RAM is deliberately left unreset.
    always_ff @(posedge iVGA_CLK) begin
        if (iWr && (state_q == StIdle)) begin
            ram_q[iWrAddr] <= iWrColor;
        end
    end

    // Lit time per step; 9-bit math keeps ON_FRAMES - 2k from wrapping.
    always_comb begin
        two_k    = 9'(step_q) << 1;
        on_diff  = (OnFrames9 > two_k) ? (OnFrames9 - two_k) : 9'd0;
        on_speed = (on_diff > MinOn9) ? on_diff : MinOn9;
        on_time  = SpeedupEn ? 8'(on_speed) : OnFrames8;
    end

    assign fcnt_inc    = fcnt_q + 8'd1;
    assign len_clamped = (iSeqLen > MaxLen) ? MaxLen : iSeqLen;
    assign last_step   = ({1'b0, step_q} == (len_q - 1'b1));

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        fcnt_d  = fcnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        if (iAbort) begin
            state_d = StIdle;
            fcnt_d  = 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (iStart) begin
                        len_d = len_clamped;
                        if (len_clamped != '0) begin
                            state_d = StOn;
                            step_d  = '0;
                            fcnt_d  = 8'd0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StOn: begin
                    if (tick) begin
                        if (fcnt_inc == on_time) begin
                            state_d = StOff;
                            fcnt_d  = 8'd0;
                        end else begin
                            fcnt_d = fcnt_inc;
                        end
                    end
                end
                StOff: begin
                    if (tick) begin
                        if (fcnt_inc == OffFrames8) begin
                            fcnt_d = 8'd0;
                            if (last_step) begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end else begin
                                step_d  = step_q + 1'b1;
                                state_d = StOn;
                            end
                        end else begin
                            fcnt_d = fcnt_inc;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        // Outputs are registered from the next state so they align with it.
        code_d = (state_d == StOn) ? ({2'b00, ram_q[step_d]} + 4'd1) : 4'd0;
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= StIdle;
            vs_q    <= 1'b1;
            step_q  <= '0;
            fcnt_q  <= 8'd0;
            len_q   <= '0;
            code_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= iVS;
            step_q  <= step_d;
            fcnt_q  <= fcnt_d;
            len_q   <= len_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oCodeColor = code_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oStep      = step_q;

endmodule

// File: tb/tb_genius_sequence_player.sv
// Scoreboard bench for genius_sequence_player: expected lit spans are queued at start and
// compared when the DUT ends each highlight.
module tb_genius_sequence_player;

    localparam int unsigned DL = 5;

    logic iVGA_CLK = 1'b0;
    always #5 iVGA_CLK = ~iVGA_CLK;

    logic          iRST_n, iVS, iWr, iStart, iAbort;
    logic [DL-1:0] iWrAddr;
    logic [1:0]    iWrColor;
    logic [DL:0]   iSeqLen;
    logic [3:0]    oCodeColor;
    logic          oBusy, oDone;
    logic [DL-1:0] oStep;

    logic          sp_wr, sp_start, sp_abort;
    logic [DL-1:0] sp_wr_addr;
    logic [1:0]    sp_wr_color;
    logic [DL:0]   sp_len;
    logic [3:0]    sp_code;
    logic          sp_busy, sp_done;
    logic [DL-1:0] sp_step;

    genius_sequence_player #(
        .DEPTH_LOG2(DL), .ON_FRAMES(2), .OFF_FRAMES(1), .MIN_ON_FRAMES(1)
    ) u_dut (
        .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iVS(iVS), .iWr(iWr), .iWrAddr(iWrAddr),
        .iWrColor(iWrColor), .iSeqLen(iSeqLen), .iStart(iStart), .iAbort(iAbort),
        .oCodeColor(oCodeColor), .oBusy(oBusy), .oDone(oDone), .oStep(oStep)
    );

    genius_sequence_player #(
        .DEPTH_LOG2(DL), .ON_FRAMES(10), .OFF_FRAMES(2), .MIN_ON_FRAMES(6)
    ) u_sp (
        .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iVS(iVS), .iWr(sp_wr), .iWrAddr(sp_wr_addr),
        .iWrColor(sp_wr_color), .iSeqLen(sp_len), .iStart(sp_start), .iAbort(sp_abort),
        .oCodeColor(sp_code), .oBusy(sp_busy), .oDone(sp_done), .oStep(sp_step)
    );

    typedef struct {
        int unsigned code;
        int unsigned ticks;
    } span_t;

    span_t       sb[$];
    span_t       sb2[$];
    int unsigned ram_m [32];
    int unsigned n_chk = 0, n_pass = 0;
    int unsigned done_cnt = 0, spans_seen = 0;
    bit          frame_tick = 1'b0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int unsigned exp_on(input int on, input int mn, input int k);
        int d;
        d = on - 2 * k;
`ifdef GENIUS_SEQ_SPEEDUP_EN
        return (d > mn) ? d : mn;
`else
        return (d > mn) ? on : on;
`endif
    endfunction

    // Frames are 8 cycles with sync low for 2; frame_tick mirrors the DUT's tick per cycle.
    initial begin
        bit vs_prev;
        int fc;
        fc  = 0;
        iVS = 1'b1;
        forever begin
            @(posedge iVGA_CLK);
            #1;
            vs_prev    = iVS;
            fc         = (fc + 1) % 8;
            iVS        = (fc < 6);
            frame_tick = vs_prev & ~iVS;
        end
    end

    // Span monitor for u_dut.
    initial begin
        bit          in_span;
        int unsigned s_code, s_ticks;
        span_t       e;
        in_span = 1'b0;
        forever begin
            @(negedge iVGA_CLK);
            if (!iRST_n) begin
                in_span = 1'b0;
            end else begin
                if (oDone) begin
                    done_cnt++;
                    check("done_with_busy", oBusy, 0);
                end
                if (oCodeColor != 4'd0) begin
                    if (!in_span) begin
                        in_span = 1'b1;
                        s_code  = oCodeColor;
                        s_ticks = 0;
                    end
                    if (frame_tick) s_ticks++;
                end else if (in_span) begin
                    in_span = 1'b0;
                    spans_seen++;
                    if (sb.size() == 0) begin
                        check("span_unexpected", s_code, 0);
                    end else begin
                        e = sb.pop_front();
                        check("span_code", s_code, e.code);
                        check("span_ticks", s_ticks, e.ticks);
                    end
                end
            end
        end
    end

    task automatic push_play(input int len);
        int n;
        n = (len > 32) ? 32 : len;
        for (int k = 0; k < n; k++) sb.push_back('{ram_m[k] + 1, exp_on(2, 1, k)});
    endtask

    task automatic wr(input int a, input int c);
        iWr = 1'b1; iWrAddr = DL'(a); iWrColor = 2'(c);
        @(posedge iVGA_CLK); #1;
        iWr = 1'b0;
    endtask

    task automatic start(input int len);
        iSeqLen = (DL + 1)'(len); iStart = 1'b1;
        @(posedge iVGA_CLK); #1;
        iStart = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < bound) begin
            @(negedge iVGA_CLK);
            seen = oDone;
            n++;
        end
        check(tag, seen, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        bit          ok, busy_seen;
        int          n;
        int unsigned ticks, c;
        span_t       e;
        iRST_n = 1'b0; iWr = 1'b0; iStart = 1'b0; iAbort = 1'b0;
        iWrAddr = '0; iWrColor = '0; iSeqLen = '0;
        sp_wr = 1'b0; sp_start = 1'b0; sp_abort = 1'b0;
        sp_wr_addr = '0; sp_wr_color = '0; sp_len = '0;
        repeat (3) @(posedge iVGA_CLK);
        #1 iRST_n = 1'b1;
        @(negedge iVGA_CLK);
        check("rst_code", oCodeColor, 0);
        check("rst_busy", oBusy, 0);
        check("rst_done", oDone, 0);
        check("rst_step", oStep, 0);
        @(posedge iVGA_CLK); #1;

        for (int k = 0; k < 32; k++) ram_m[k] = k % 4;
        ram_m[0] = 0; ram_m[1] = 3; ram_m[2] = 2;
        for (int k = 0; k < 32; k++) wr(k, ram_m[k]);

        // Basic playback, with start and write attempts while busy.
        done_cnt = 0;
        push_play(3);
        start(3);
        @(negedge iVGA_CLK);
        check("start_busy", oBusy, 1);
        check("start_code", oCodeColor, 1);
        @(posedge iVGA_CLK); #1;
        repeat (10) @(posedge iVGA_CLK);
        #1;
        iStart = 1'b1; iSeqLen = 1; iWr = 1'b1; iWrAddr = 0; iWrColor = 2'd1;
        @(posedge iVGA_CLK); #1;
        iStart = 1'b0; iWr = 1'b0;
        wait_done("basic_done", 2000);
        check("basic_sb_left", sb.size(), 0);
        check("basic_done_pulses", done_cnt, 1);
        check("basic_step_hold", oStep, 2);
        @(posedge iVGA_CLK); #1;

        // Zero length.
        done_cnt = 0;
        start(0);
        @(negedge iVGA_CLK);
        check("zero_done", oDone, 1);
        busy_seen = oBusy;
        repeat (5) begin
            @(negedge iVGA_CLK);
            busy_seen |= oBusy;
        end
        check("zero_busy_never", busy_seen, 0);
        check("zero_done_pulses", done_cnt, 1);
        @(posedge iVGA_CLK); #1;

        // Length above depth clamps to 32 steps; step 0 still red despite busy write.
        done_cnt = 0; spans_seen = 0;
        push_play(40);
        start(40);
        wait_done("clamp_done", 8000);
        check("clamp_sb_left", sb.size(), 0);
        check("clamp_spans", spans_seen, 32);
        check("clamp_step", oStep, 31);
        check("clamp_done_pulses", done_cnt, 1);
        @(posedge iVGA_CLK); #1;

        // Abort during step 1 OFF.
        done_cnt = 0;
        push_play(3);
        start(3);
        ok = 1'b0; n = 0;
        while (!ok && n < 2000) begin
            @(negedge iVGA_CLK);
            ok = (oStep == 1) && (oCodeColor != 4'd0);
            n++;
        end
        while (ok && oCodeColor != 4'd0 && n < 4000) begin
            @(negedge iVGA_CLK);
            n++;
        end
        check("abort_reach_off", ok && (oCodeColor == 4'd0) && oBusy, 1);
        @(posedge iVGA_CLK); #1;
        iAbort = 1'b1;
        @(posedge iVGA_CLK); #1;
        iAbort = 1'b0;
        @(negedge iVGA_CLK);
        check("abort_busy", oBusy, 0);
        check("abort_code", oCodeColor, 0);
        check("abort_sb_left", sb.size(), 1);
        sb.delete();
        repeat (40) @(negedge iVGA_CLK);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", oBusy, 0);
        @(posedge iVGA_CLK); #1;

        // Speedup instance: lit ticks per step.
        for (int k = 0; k < 5; k++) begin
            sp_wr = 1'b1; sp_wr_addr = DL'(k); sp_wr_color = 2'((k + 3) % 4);
            @(posedge iVGA_CLK); #1;
        end
        sp_wr = 1'b0;
        for (int k = 0; k < 5; k++) sb2.push_back('{((k + 3) % 4) + 1, exp_on(10, 6, k)});
        sp_len = 5; sp_start = 1'b1;
        @(posedge iVGA_CLK); #1;
        sp_start = 1'b0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            while (sp_code == 4'd0 && n < 3000) begin
                @(negedge iVGA_CLK);
                n++;
            end
            c = sp_code; ticks = 0;
            while (sp_code != 4'd0 && n < 3000) begin
                if (frame_tick) ticks++;
                @(negedge iVGA_CLK);
                n++;
            end
            e = sb2.pop_front();
            check($sformatf("sp_code%0d", k), c, e.code);
            check($sformatf("sp_ticks%0d", k), ticks, e.ticks);
        end
        ok = 1'b0;
        while (!ok && n < 3500) begin
            @(negedge iVGA_CLK);
            ok = sp_done;
            n++;
        end
        check("sp_done", ok, 1);
        check("sp_step", sp_step, 4);
        check("sp_busy", sp_busy, 0);
        @(posedge iVGA_CLK); #1;

        // Asynchronous reset while step 1 is lit.
        done_cnt = 0;
        push_play(3);
        start(3);
        ok = 1'b0; n = 0;
        while (!ok && n < 2000) begin
            @(negedge iVGA_CLK);
            ok = (oStep == 1) && (oCodeColor != 4'd0);
            n++;
        end
        check("rst_mid_on_reached", ok, 1);
        #2 iRST_n = 1'b0;
        #1;
        check("rst_mid_code", oCodeColor, 0);
        check("rst_mid_busy", oBusy, 0);
        check("rst_mid_step", oStep, 0);
        check("rst_mid_done", oDone, 0);
        sb.delete();
        repeat (2) @(posedge iVGA_CLK);
        #1 iRST_n = 1'b1;
        repeat (30) @(negedge iVGA_CLK);
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_idle", oBusy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
